// File: rtl/approx_error_monitor.sv
// approx_error_monitor
//   Measures the accuracy of an 8-bit approximate adder over a window of
//   WINDOW samples. Each accepted sample is compared against the exact
//   9-bit sum A + B + cin. The error distance is |exact - approx|. The block
//   accumulates the error count, the error-distance sum, the maximum error
//   distance and the number of samples. It then presents the statistics
//   through a valid/ready handshake.
//
// Ports
//   clk           : clock, all state changes on the rising edge
//   rst_n         : synchronous active-low reset
//   start         : one-cycle pulse that opens a window (honoured in IDLE only)
//   in_valid      : sample on A/B/cin/approx_* is valid
//   in_ready      : block accepts a sample this cycle (ACCUM only)
//   A, B, cin     : operands of the adder under test
//   approx_sum    : 8-bit sum from the adder under test
//   approx_cout   : carry-out from the adder under test
//   result_valid  : window statistics are valid (REPORT)
//   result_ready  : consumer takes the statistics
//   err_count     : samples in the window with nonzero error distance
//   err_sum       : sum of error distances over the window
//   err_max       : largest error distance in the window
//   sample_cnt    : samples accepted in the current window
module approx_error_monitor #(
  parameter int WINDOW = 256,
  parameter int SUM_W  = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic             cin,
  input  logic [7:0]       approx_sum,
  input  logic             approx_cout,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [15:0]      err_count,
  output logic [SUM_W-1:0] err_sum,
  output logic [8:0]       err_max,
  output logic [15:0]      sample_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Absolute difference of two unsigned 9-bit values. The 10-bit signed
  // intermediate covers the full range -511..511, so the result never
  // exceeds 511 and fits back into 9 bits.
  function automatic logic [8:0] abs_dist(input logic [8:0] exact,
                                          input logic [8:0] approx);
    logic signed [9:0] diff;
    diff = $signed({1'b0, exact}) - $signed({1'b0, approx});
    return (diff < 0) ? 9'(-diff) : 9'(diff);
  endfunction

  // ---- stage p0: error distance of the presented sample ----
  logic [8:0] exact_p0;
  logic [8:0] approx_p0;
  logic [8:0] ed_p0;
  logic       vld_p0;
  logic       last_p0;

  assign exact_p0  = {1'b0, A} + {1'b0, B} + {8'd0, cin};
  assign approx_p0 = {approx_cout, approx_sum};
  assign ed_p0     = abs_dist(exact_p0, approx_p0);
  assign vld_p0    = in_valid & in_ready;
  // sample_cnt still holds the pre-accept count, so the final sample of
  // the window arrives when it equals WINDOW-1.
  assign last_p0   = vld_p0 && (sample_cnt == 16'(WINDOW - 1));

  assign in_ready     = (state_q == ACCUM);
  assign result_valid = (state_q == REPORT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)        state_d = ACCUM;
      ACCUM:   if (last_p0)      state_d = REPORT;
      REPORT:  if (result_ready) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- stage p1: window statistics ----
  // Statistics are cleared only when a window opens. They therefore stay
  // readable in IDLE after the handshake until the next start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count  <= '0;
      err_sum    <= '0;
      err_max    <= '0;
      sample_cnt <= '0;
    end else if (state_q == IDLE && start) begin
      err_count  <= '0;
      err_sum    <= '0;
      err_max    <= '0;
      sample_cnt <= '0;
    end else if (vld_p0) begin
      sample_cnt <= sample_cnt + 16'd1;
      err_sum    <= err_sum + SUM_W'(ed_p0);
      err_count  <= err_count + 16'(ed_p0 != 9'd0);
      if (ed_p0 > err_max) begin
        err_max <= ed_p0;
      end
    end
  end

endmodule

// File: doc/approx_error_monitor.md
APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

Interface
REQ-001 SHALL have parameter WINDOW, default 256: number of samples per measurement window, legal range 1..65535.
REQ-002 SHALL have parameter SUM_W, default 25: width of the error-distance accumulator; 25 holds 511*65535 without overflow.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1: a one-cycle pulse that opens a window.
REQ-006 SHALL have port in_valid, input, 1: the sample on A/B/cin/approx_* is valid.
REQ-007 SHALL have port in_ready, output, 1: the block accepts a sample this cycle.
REQ-008 SHALL have port A, input, 8: adder operand A.
REQ-009 SHALL have port B, input, 8: adder operand B.
REQ-010 SHALL have port cin, input, 1: adder carry-in.
REQ-011 SHALL have port approx_sum, input, 8: sum produced by the 8-bit approximate adder under test.
REQ-012 SHALL have port approx_cout, input, 1: carry-out produced by the adder under test.
REQ-013 SHALL have port result_valid, output, 1: window statistics are valid.
REQ-014 SHALL have port result_ready, input, 1: the consumer takes the statistics.
REQ-015 SHALL have port err_count, output, 16: number of samples in the window with nonzero error.
REQ-016 SHALL have port err_sum, output, SUM_W: sum of error distances over the window.
REQ-017 SHALL have port err_max, output, 9: largest error distance in the window.
REQ-018 SHALL have port sample_cnt, output, 16: number of samples accepted in the current window.

Function
REQ-019 SHALL compute exact = A + B + cin as a 9-bit value and approx = {approx_cout, approx_sum} as a 9-bit value.
REQ-020 SHALL define error distance ED = |exact - approx|, unsigned, 9 bits, range 0..511.
REQ-021 SHALL implement FSM states IDLE, ACCUM and REPORT.
REQ-022 SHALL move IDLE->ACCUM on start=1 and, in the same edge, clear err_count, err_sum, err_max and sample_cnt.
REQ-023 SHALL drive in_ready=1 only in ACCUM.
REQ-024 SHALL accept a sample on any edge where in_valid and in_ready are both 1; in_valid while in_ready=0 is ignored with no state change.
REQ-025 On accept, SHALL do all of the following on the same edge:
- sample_cnt += 1;
- err_sum += ED;
- err_count += 1 if ED != 0;
- err_max = max(err_max, ED).
REQ-026 SHALL move ACCUM->REPORT on the edge that accepts sample number WINDOW; in_ready is 0 from the next cycle.
REQ-027 SHALL hold result_valid=1 in REPORT, with all statistics held stable until the handshake completes.
REQ-028 SHALL move REPORT->IDLE on the edge where result_valid and result_ready are both 1; statistics keep their values in IDLE until the next start.
REQ-029 SHALL ignore start in ACCUM and REPORT; a window cannot be restarted except by reset.
REQ-030 With WINDOW=1, SHALL move ACCUM->REPORT on the first accept.
REQ-031 SHALL not saturate or wrap err_sum for any legal WINDOW at SUM_W=25.
REQ-032 SHALL have latency from the final accept to result_valid=1 of exactly 1 cycle.

Reset
REQ-033 When rst_n=0 at a clock edge, SHALL set the FSM to IDLE and set in_ready, result_valid, err_count, err_sum, err_max and sample_cnt to 0.
REQ-034 Reset asserted mid-ACCUM or mid-REPORT SHALL discard the window; no result_valid pulse follows.
REQ-035 SHALL ignore start during the cycle rst_n=0.

Verification
REQ-036 Single sample, WINDOW=1: A=0x0F, B=0x01, cin=0, approx_sum=0x01, approx_cout=0 (ED=15) -> result_valid next cycle; err_count=1, err_sum=15, err_max=15, sample_cnt=1.
REQ-037 Exact samples, WINDOW=4: four samples with approx = exact (e.g. 0x10+0x20=0x030) -> err_count=0, err_sum=0, err_max=0, sample_cnt=4.
REQ-038 Extreme error, WINDOW=2: sample 1 A=0xFF, B=0xFF, cin=1 (exact=0x1FF) with approx=0x000, then sample 2 with ED=3 -> err_count=2, err_sum=514, err_max=511.
REQ-039 Back-pressure, WINDOW=3: in_valid toggled 1,0,1,0,1 with result_ready held 0 for 5 cycles -> statistics stable while held; in_ready=0 throughout REPORT; FSM reaches IDLE on the cycle result_ready=1.
REQ-040 Reset mid-window, WINDOW=8: 3 samples accepted, then rst_n=0 for 1 cycle -> all outputs 0 and FSM in IDLE; a new start then yields a window counted from sample_cnt=0.
REQ-041 Stray start, WINDOW=4: start pulsed during ACCUM after 2 samples -> ignored; sample_cnt continues 3, 4; REPORT is entered normally.
